// File: rtl/bcd_demux_pkg.sv
// Shared types, constants and width helper for the BCD demultiplexer.
// Optional feature macro used by this block: BCD_DEMUX_RANGE_CHECK_EN.
package bcd_demux_pkg;

    localparam int unsigned NIB_W   = 4;
    localparam int unsigned BCD_MAX = 9;

    typedef logic [NIB_W-1:0] bcd_nib_t;

    // Per-dwell decision state.
    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_HELD  = 2'd2
    } bcd_state_e;

    // Bits needed to hold values 0..value-1 (at least one bit).
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned w;
        int unsigned span;
        w    = 1;
        span = 2;
        while (span < value) begin
            w    = w + 1;
            span = span << 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_demux_if.sv
// Bus between a digit-multiplexed BCD source and the demultiplexer.
// The o_digit_err line exists only when BCD_DEMUX_RANGE_CHECK_EN is defined.
interface bcd_demux_if #(
    parameter int unsigned DISPLAYS_NUM = 4
);
    import bcd_demux_pkg::*;

    bcd_nib_t                        i_bcd_muxed;
    logic [DISPLAYS_NUM-1:0]         i_bcd_sel;
    logic [DISPLAYS_NUM*NIB_W-1:0]   o_bcd_data;
    logic                            o_frame_valid;
    logic                            o_sel_err;
    logic                            o_timeout;
`ifdef BCD_DEMUX_RANGE_CHECK_EN
    logic                            o_digit_err;

    modport master (
        output i_bcd_muxed, i_bcd_sel,
        input  o_bcd_data, o_frame_valid, o_sel_err, o_timeout, o_digit_err
    );
    modport slave (
        input  i_bcd_muxed, i_bcd_sel,
        output o_bcd_data, o_frame_valid, o_sel_err, o_timeout, o_digit_err
    );
`else
    modport master (
        output i_bcd_muxed, i_bcd_sel,
        input  o_bcd_data, o_frame_valid, o_sel_err, o_timeout
    );
    modport slave (
        input  i_bcd_muxed, i_bcd_sel,
        output o_bcd_data, o_frame_valid, o_sel_err, o_timeout
    );
`endif

endinterface

// File: rtl/bcd_sel_stable.sv
// Select-stability tracker: registers the select, counts how long it has
// been unchanged (saturating) and decodes it as one-hot.
module bcd_sel_stable
    import bcd_demux_pkg::*;
#(
    parameter int unsigned SEL_W         = 4,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SEL_W-1:0]            sel_in,
    output logic                        change_c,
    output logic                        ripe_c,
    output logic                        ripe_next_c,
    output logic                        onehot_c,
    output logic [clogb2(SEL_W)-1:0]    idx_c
);
    localparam int unsigned CNT_W = clogb2(STABLE_CYCLES + 1);
    localparam int unsigned IDX_W = clogb2(SEL_W);

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Dwell age: restarts when a new select is registered, saturates at STABLE_CYCLES.
    always_comb begin
        sel_d       = sel_in;
        cnt_d       = cnt_q;
        change_c    = (sel_in != sel_q);
        if (change_c) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        ripe_c      = (cnt_q == CNT_W'(STABLE_CYCLES - 1));
        ripe_next_c = (cnt_d == CNT_W'(STABLE_CYCLES - 1));
        onehot_c    = $onehot(sel_q);
        idx_c       = '0;
        for (int unsigned k = 0; k < SEL_W; k++) begin
            if (sel_q[k]) begin
                idx_c = IDX_W'(k);
            end
        end
    end

    // Registered select and its age.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
            cnt_q <= '0;
        end else begin
            sel_q <= sel_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_demux.sv
// BCD demultiplexer: rebuilds a DISPLAYS_NUM-digit word from a scanned
// nibble/select pair and publishes it atomically once every digit is seen.
// Optional: BCD_DEMUX_RANGE_CHECK_EN rejects nibbles above 9 via o_digit_err.
module bcd_demux
    import bcd_demux_pkg::*;
#(
    parameter int unsigned DISPLAYS_NUM   = 4,
    parameter int unsigned STABLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    bcd_demux_if.slave  bus
);
    localparam int unsigned IDX_W  = clogb2(DISPLAYS_NUM);
    localparam int unsigned TMO_W  = clogb2(TIMEOUT_CYCLES);
    localparam int unsigned DATA_W = DISPLAYS_NUM * NIB_W;

    logic                     sel_change_c, ripe_c, ripe_next_c, onehot_c;
    logic [IDX_W-1:0]         sel_idx_c;
    logic                     act_c, capture_c, nib_ok_c;

    bcd_nib_t                 r_nib_q, r_nib_d;
    bcd_state_e               state_q, state_d;
    bcd_nib_t                 slot_q [DISPLAYS_NUM];
    bcd_nib_t                 slot_d [DISPLAYS_NUM];
    logic [DISPLAYS_NUM-1:0]  seen_q, seen_d;
    logic [DATA_W-1:0]        data_q, data_d;
    logic                     frame_valid_q, frame_valid_d;
    logic                     sel_err_q, sel_err_d;
    logic                     timeout_q, timeout_d;
    logic [TMO_W-1:0]         tmo_cnt_q, tmo_cnt_d;
`ifdef BCD_DEMUX_RANGE_CHECK_EN
    logic                     digit_err_q, digit_err_d;
`endif

    bcd_sel_stable #(
        .SEL_W         (DISPLAYS_NUM),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_sel_stable (
        .clk         (i_clk),
        .rst         (i_rst),
        .sel_in      (bus.i_bcd_sel),
        .change_c    (sel_change_c),
        .ripe_c      (ripe_c),
        .ripe_next_c (ripe_next_c),
        .onehot_c    (onehot_c),
        .idx_c       (sel_idx_c)
    );

    // Dwell FSM: one decision per dwell, restarted by any select change.
    always_comb begin
        state_d = state_q;
        act_c   = (state_q == ST_CHECK) || ((state_q == ST_WAIT) && ripe_c);
        if (sel_change_c) begin
            state_d = ripe_next_c ? ST_CHECK : ST_WAIT;
        end else begin
            case (state_q)
                ST_WAIT:  if (act_c) state_d = ST_HELD;
                          else if (ripe_next_c) state_d = ST_CHECK;
                ST_CHECK: state_d = ST_HELD;
                ST_HELD:  state_d = ST_HELD;
                default:  state_d = ST_WAIT;
            endcase
        end
    end

    // Capture, frame assembly and idle timeout; a capture beats a timeout.
    always_comb begin
        r_nib_d       = bus.i_bcd_muxed;
        slot_d        = slot_q;
        seen_d        = seen_q;
        data_d        = data_q;
        frame_valid_d = 1'b0;
        sel_err_d     = 1'b0;
        timeout_d     = timeout_q;
        tmo_cnt_d     = tmo_cnt_q;
        capture_c     = 1'b0;
`ifdef BCD_DEMUX_RANGE_CHECK_EN
        digit_err_d   = 1'b0;
        nib_ok_c      = (r_nib_q <= NIB_W'(BCD_MAX));
`else
        nib_ok_c      = 1'b1;
`endif
        if (act_c) begin
            if (!onehot_c) begin
                sel_err_d = 1'b1;
            end else if (!nib_ok_c) begin
`ifdef BCD_DEMUX_RANGE_CHECK_EN
                digit_err_d = 1'b1;
`endif
            end else begin
                capture_c         = 1'b1;
                slot_d[sel_idx_c] = r_nib_q;
                seen_d[sel_idx_c] = 1'b1;
            end
        end
        if (capture_c) begin
            tmo_cnt_d = '0;
            timeout_d = 1'b0;
            if (&seen_d) begin
                for (int unsigned k = 0; k < DISPLAYS_NUM; k++) begin
                    data_d[NIB_W*(DISPLAYS_NUM-1-k) +: NIB_W] = slot_d[k];
                end
                frame_valid_d = 1'b1;
                seen_d        = '0;
            end
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            seen_d    = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_nib_q       <= '0;
            state_q       <= ST_WAIT;
            for (int unsigned k = 0; k < DISPLAYS_NUM; k++) begin
                slot_q[k] <= '0;
            end
            seen_q        <= '0;
            data_q        <= '0;
            frame_valid_q <= 1'b0;
            sel_err_q     <= 1'b0;
            timeout_q     <= 1'b0;
            tmo_cnt_q     <= '0;
`ifdef BCD_DEMUX_RANGE_CHECK_EN
            digit_err_q   <= 1'b0;
`endif
        end else begin
            r_nib_q       <= r_nib_d;
            state_q       <= state_d;
            slot_q        <= slot_d;
            seen_q        <= seen_d;
            data_q        <= data_d;
            frame_valid_q <= frame_valid_d;
            sel_err_q     <= sel_err_d;
            timeout_q     <= timeout_d;
            tmo_cnt_q     <= tmo_cnt_d;
`ifdef BCD_DEMUX_RANGE_CHECK_EN
            digit_err_q   <= digit_err_d;
`endif
        end
    end

    assign bus.o_bcd_data    = data_q;
    assign bus.o_frame_valid = frame_valid_q;
    assign bus.o_sel_err     = sel_err_q;
    assign bus.o_timeout     = timeout_q;
`ifdef BCD_DEMUX_RANGE_CHECK_EN
    assign bus.o_digit_err   = digit_err_q;
`endif

endmodule

// File: doc/bcd_demux.md
BCD_DEMUX -- requirements
Module: bcd_demux

Interface
REQ-001 Parameter DISPLAYS_NUM, default 4: number of multiplexed digits; range 2..8.
REQ-002 Parameter STABLE_CYCLES, default 2: number of consecutive cycles a select must hold before its nibble is captured; range 1..15.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: number of cycles without a capture before timeout is declared.
REQ-004 i_clk  input  1  single clock, rising edge.
REQ-005 i_rst  input  1  reset, asynchronous and active-high.
REQ-006 i_bcd_muxed  input  4  time-multiplexed BCD nibble.
REQ-007 i_bcd_sel  input  DISPLAYS_NUM  one-hot digit select; bit k means digit k is present.
REQ-008 o_bcd_data  output  DISPLAYS_NUM*4  reassembled word; digit k at bits [4*(DISPLAYS_NUM-1-k) +: 4].
REQ-009 o_frame_valid  output  1  one-cycle pulse when o_bcd_data is updated.
REQ-010 o_sel_err  output  1  one-cycle pulse when a stable select is zero or multi-hot.
REQ-011 o_timeout  output  1  level; set on timeout, cleared by the next capture.

Function
REQ-012 The block SHALL register i_bcd_muxed and i_bcd_sel once (r_nib, r_sel) before any decision.
REQ-013 A stability counter SHALL reset to 0 whenever r_sel differs from its previous value, and SHALL otherwise increment, saturating at STABLE_CYCLES.
REQ-014 FSM states:
  - WAIT: counter < STABLE_CYCLES-1.
  - CHECK: counter == STABLE_CYCLES-1.
  - HELD: capture done for the current dwell.
  - A select change SHALL return the FSM to WAIT from any state.
REQ-015 In CHECK with one-hot r_sel = bit k, the block SHALL:
  - write r_nib into holding slot k;
  - set seen[k];
  - go to HELD.
  - At most one capture SHALL occur per dwell.
REQ-016 In CHECK with r_sel zero or multi-hot, the block SHALL pulse o_sel_err for one cycle, capture nothing, and go to HELD.
REQ-017 On the edge where seen becomes all-ones, the block SHALL, in that same edge:
  - load o_bcd_data from the holding slots, including the nibble being captured;
  - pulse o_frame_valid the following cycle;
  - clear seen.
  - o_bcd_data SHALL otherwise hold its value (atomic frame update).
REQ-018 Recapturing a digit already in seen SHALL overwrite its slot without producing a frame; last value wins.
REQ-019 Latency: the frame-completing select appears at the input in cycle t and is held; o_frame_valid SHALL assert in cycle t+1+STABLE_CYCLES.
REQ-020 Timeout counter behaviour:
  - SHALL reset on every capture and increment otherwise;
  - at TIMEOUT_CYCLES-1 it SHALL set o_timeout, clear seen and saturate.
  - o_bcd_data SHALL keep its last frame.
REQ-021 A capture and a timeout in the same cycle SHALL resolve in favour of the capture.

Reset
REQ-022 Asserting i_rst SHALL, asynchronously:
  - clear o_bcd_data, o_frame_valid, o_sel_err, o_timeout, seen, the holding slots and both counters;
  - set r_sel to 0;
  - set the FSM to WAIT.
REQ-023 Reset asserted mid-frame SHALL discard partial captures; no frame SHALL be produced from pre-reset digits.

Configuration
REQ-024 With BCD_DEMUX_RANGE_CHECK_EN defined, a captured nibble above 9 SHALL:
  - pulse output o_digit_err;
  - not be written or marked seen.
REQ-025 Without BCD_DEMUX_RANGE_CHECK_EN, o_digit_err SHALL NOT exist and all nibbles 0..15 SHALL be accepted.

Structure
REQ-026 A shared package SHALL hold:
  - the FSM state encoding (WAIT, CHECK, HELD);
  - the clogb2 width helper;
  - the constant BCD_MAX = 9.
REQ-027 The select-stability tracker (counter plus one-hot check) SHALL be one sub-module, bcd_sel_stable; the rest of the logic stays in bcd_demux.

Verification (DISPLAYS_NUM=4, STABLE_CYCLES=2)
REQ-028 Sel 0001/0010/0100/1000 carrying nibbles 1/2/3/4, each held 3 cycles -> o_bcd_data=16'h1234, one o_frame_valid pulse at the cycle given in REQ-019.
REQ-029 Sel 0001 held 1 cycle, then normal scan with digits 5,6,7,8 -> the glitch is not captured; o_bcd_data=16'h5678.
REQ-030 Sel 0011 held 4 cycles -> exactly one o_sel_err pulse; seen unchanged; no frame.
REQ-031 Digits 0 and 1 captured, then no select change for 1024 cycles -> o_timeout=1, previous o_bcd_data kept; a full scan afterwards yields a new frame and o_timeout=0.
REQ-032 i_rst pulsed after 3 of 4 digits, then a scan of 9,8,7,6 -> o_bcd_data=16'h9876 with no earlier frame pulse.
REQ-033 With BCD_DEMUX_RANGE_CHECK_EN defined, nibble 4'hA on sel 0100 -> one o_digit_err pulse; no frame until digit 2 is recaptured with a valid value.
